// File: rtl/serial_addsub_4bit_pkg.sv
// serial_addsub_4bit_pkg: shared state encoding and sizing for the serial adder/subtractor
package serial_addsub_4bit_pkg;
   localparam int DEF_WIDTH = 4;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;
   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction
endpackage

// File: rtl/serial_addsub_4bit_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder shared by serial datapaths
module serial_fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_addsub_4bit.sv
// serial_addsub_4bit: LSB-first bit-serial adder/subtractor with start/done handshake
module serial_addsub_4bit
   import serial_addsub_4bit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);
   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, carry_q, carry_d, ovf_q, ovf_d;
   logic             fa_s, fa_co;

   serial_fa_cell u_fa (
      .x  (a_q[0]),
      .y  (b_q[0]),
      .ci (c_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // Next-state and datapath: latch operands in IDLE, one bit per edge in SHIFT, publish on the last bit
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: if (start) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            c_d     = sub | cin;
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = {fa_s, r_q[WIDTH-1:1]};
            c_d   = fa_co;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {fa_s, r_q[WIDTH-1:1]};
               carry_d = fa_co;
               ovf_d   = c_q ^ fa_co;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, operand, partial-result and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == ST_SHIFT);
   assign done     = (state_q == ST_DONE);
   assign sum      = sum_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub_4bit.sv
// tb_serial_addsub_4bit: directed and exhaustive checks of the serial adder/subtractor
module tb_serial_addsub_4bit;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       sub = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       cin = 1'b0;
   logic       busy, done, carry, overflow;
   logic [3:0] sum;
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;

   serial_addsub_4bit #(.WIDTH(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carry    (carry),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Free-running cycle count used to measure done spacing
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic [3:0] es, input logic ec, input logic eo);
      chk({tag, ".sum"}, 32'(sum), 32'(es));
      chk({tag, ".carry"}, 32'(carry), 32'(ec));
      chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
   endtask

   // Issue one operation and wait for done; lat counts cycles after the start edge, bcnt counts busy cycles
   task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic ic, input logic is,
                         output int lat, output int bcnt);
      @(negedge clk);
      a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      bcnt = 0;
      while (!done && lat < 20) begin
         bcnt += int'(busy);
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) chk("done_timeout", 32'(lat), 32'd5);
   endtask

   initial begin
      int lat, bcnt, ndone, last;
      logic [3:0] bb, es;
      logic [4:0] full;
      repeat (3) @(negedge clk);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk_res("rst", 4'h0, 1'b0, 1'b0);
      reset_n = 1'b1;

      run_op(4'b1111, 4'b0001, 1'b0, 1'b0, lat, bcnt);
      chk("wrap.lat", 32'(lat), 5);
      chk("wrap.busy", 32'(bcnt), 4);
      chk_res("wrap", 4'b0000, 1'b1, 1'b0);
      @(negedge clk);
      chk("wrap.done_pulse", 32'(done), 0);

      run_op(4'b0111, 4'b0001, 1'b0, 1'b0, lat, bcnt);
      chk_res("add7p1", 4'b1000, 1'b0, 1'b1);
      run_op(4'b0101, 4'b0010, 1'b1, 1'b0, lat, bcnt);
      chk_res("add5p2c", 4'b1000, 1'b0, 1'b1);
      run_op(4'b0011, 4'b0101, 1'b1, 1'b1, lat, bcnt);
      chk_res("sub3m5", 4'b1110, 1'b0, 1'b0);
      run_op(4'b1000, 4'b0001, 1'b0, 1'b1, lat, bcnt);
      chk_res("sub8m1", 4'b0111, 1'b1, 1'b1);
      run_op(4'b1010, 4'b1010, 1'b0, 1'b1, lat, bcnt);
      chk_res("subeq", 4'b0000, 1'b1, 1'b0);

      // Second start mid-operation must be ignored
      @(negedge clk);
      a = 4'b0101; b = 4'b0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 4'b1111; b = 4'b1111;
      @(negedge clk);
      start = 1'b1; sub = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_res("ign.hold", 4'b0000, 1'b1, 1'b0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            ndone++;
            chk_res("ign.res", 4'b0110, 1'b0, 1'b0);
         end
         @(negedge clk);
      end
      chk("ign.ndone", 32'(ndone), 1);

      // Reset mid-SHIFT discards the operation
      a = 4'b0110; b = 4'b0011; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort.busy", 32'(busy), 0);
      chk("abort.done", 32'(done), 0);
      chk_res("abort", 4'h0, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         ndone += int'(done);
         @(negedge clk);
      end
      chk("abort.ndone", 32'(ndone), 0);
      run_op(4'b0010, 4'b0011, 1'b0, 1'b0, lat, bcnt);
      chk("post.lat", 32'(lat), 5);
      chk_res("post", 4'b0101, 1'b0, 1'b0);

      // Exhaustive sweep with start held high
      @(negedge clk);
      ndone = 0;
      last = 0;
      start = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         logic [9:0] v;
         int t;
         v = 10'(i);
         a = v[3:0]; b = v[7:4]; cin = v[8]; sub = v[9];
         t = 0;
         do begin
            @(negedge clk);
            t++;
         end while (!done && t < 20);
         if (!done) begin
            chk("sweep.timeout", 32'(t), 6);
            break;
         end
         ndone++;
         if (i > 0) chk("sweep.gap", 32'(cyc - last), 6);
         last = cyc;
         bb = v[9] ? ~v[7:4] : v[7:4];
         full = {1'b0, v[3:0]} + {1'b0, bb} + 5'(v[9] | v[8]);
         es = full[3:0];
         chk_res("sweep", es, full[4], (v[3] == bb[3]) && (es[3] != v[3]));
      end
      start = 1'b0;
      chk("sweep.ndone", 32'(ndone), 1024);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
